// File: rtl/axi_frame_reader.sv
// axi_frame_reader: AXI4 read master that fetches a 32-bit-per-pixel
// framebuffer (row-major, pixel (0,0) at C_M_AXI_TARGET_SLAVE_BASE_ADDR) and
// emits one frame as 24-bit RGB AXI4-Stream video (tuser = start of frame,
// tlast = end of line). Bursts are issued only when the pixel FIFO has room
// for a whole burst, so read data is never dropped.
// Optional feature: define AXI_FRAME_READER_LOOP_EN for continuous refresh
// (the frame restarts while frame_start is held high).
module axi_frame_reader #(
    parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          FRAME_WIDTH                    = 1920,
    parameter int          FRAME_HEIGHT                   = 1080,
    parameter int          BURST_LEN                      = 16,
    parameter int          FIFO_DEPTH                     = 64
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    // AXI4 read address channel
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    // AXI4 read data channel
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    // AXI4-Stream video
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    // Frame control / status
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        frame_error
);

    localparam int NUM_BURSTS = FRAME_WIDTH * FRAME_HEIGHT / BURST_LEN;
    localparam int BW = $clog2(NUM_BURSTS + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int LW = $clog2(BURST_LEN + 1);

    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
    localparam logic [31:0] DEPTH_32    = 32'(FIFO_DEPTH);
    localparam logic [31:0] BLEN_32     = 32'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic            start_q;
    logic            start_edge;
    logic            accept;
    logic            frame_end;
    logic            loop_restart;
    logic            room_ok;
    logic            ar_hs;
    logic            r_hs;
    logic            pix_hs;
    logic            last_pix;
    logic [BW-1:0]   burst_idx;
    logic [LW-1:0]   beats_out;

    logic [23:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic            x_last;
    logic            y_last;

    // The pad byte of each pixel word carries no information.
    logic            unused_pad;
    assign unused_pad = ^m_axi_rdata[31:24];

    // Constant AR channel fields.
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'h2;
    assign m_axi_arburst = 2'h1;
    assign m_axi_arcache = 4'h2;
    assign m_axi_arprot  = 3'h0;

    assign start_edge = frame_start & ~start_q;

    assign m_axi_arvalid = (state == S_ADDR);
    assign m_axi_rready  = (state == S_DATA);
    assign m_axi_araddr  = m_axi_arvalid
                         ? C_M_AXI_TARGET_SLAVE_BASE_ADDR + 32'(burst_idx) * BURST_BYTES
                         : '0;
    assign frame_busy    = (state != S_IDLE);

    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rvalid & m_axi_rready;
    assign pix_hs = m_axis_tvalid & m_axis_tready;

    // Free entries must cover a full burst, counting beats still in flight.
    assign room_ok = (32'(fifo_count) + 32'(beats_out) + BLEN_32) <= DEPTH_32;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;

    assign x_last       = (x_cnt == XW'(FRAME_WIDTH - 1));
    assign y_last       = (y_cnt == YW'(FRAME_HEIGHT - 1));
    assign m_axis_tuser = m_axis_tvalid & (x_cnt == '0) & (y_cnt == '0);
    assign m_axis_tlast = m_axis_tvalid & x_last;
    assign last_pix     = pix_hs & x_last & y_last;

    // State register and start-edge history.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= frame_start;
        end
    end

    // Next-state logic and one-cycle control strobes.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value held, which would infer a latch.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        frame_end    = 1'b0;
        loop_restart = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (room_ok) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (m_axi_arready) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (m_axi_rvalid && m_axi_rlast) begin
                    state_nxt = (burst_idx == BW'(NUM_BURSTS)) ? S_DRAIN : S_REQ;
                end
            end
            S_DRAIN: begin
                if (last_pix) begin
                    frame_end = 1'b1;
`ifdef AXI_FRAME_READER_LOOP_EN
                    if (frame_start) begin
                        loop_restart = 1'b1;
                        state_nxt    = S_REQ;
                    end else begin
                        state_nxt    = S_IDLE;
                    end
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst index, in-flight beat count and frame status flags.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            burst_idx   <= '0;
            beats_out   <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (accept || loop_restart) begin
                burst_idx <= '0;
            end else if (ar_hs) begin
                burst_idx <= burst_idx + BW'(1);
            end

            if (ar_hs) begin
                beats_out <= LW'(BURST_LEN);
            end else if (r_hs && beats_out != '0) begin
                beats_out <= beats_out - LW'(1);
            end

            frame_done <= frame_end;

            if (accept) begin
                frame_error <= 1'b0;
            end else if (r_hs && m_axi_rresp != 2'b00) begin
                frame_error <= 1'b1;
            end
        end
    end

    // FIFO storage.
    // NOTE: the pixel array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never presented.
    always_ff @(posedge m_axi_aclk) begin
        if (r_hs) fifo_mem[wr_ptr] <= m_axi_rdata[23:0];
    end

    // FIFO pointers and occupancy; write and read together keep the count.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (r_hs)   wr_ptr <= wr_ptr + AW'(1);
            if (pix_hs) rd_ptr <= rd_ptr + AW'(1);
            case ({r_hs, pix_hs})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output raster position, advanced on each stream handshake.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_hs) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Bursts are only requested with room reserved, so a write into a full
    // FIFO indicates a broken space calculation.
    a_no_overflow: assert property (@(posedge m_axi_aclk) disable iff (!m_axi_aresetn)
        !(r_hs && fifo_full));

    a_full_empty_exclusive: assert property (@(posedge m_axi_aclk) disable iff (!m_axi_aresetn)
        !(fifo_full && fifo_empty));

endmodule

// File: tb/tb_axi_frame_reader.sv
// Testbench for axi_frame_reader on an 8x2 frame with 4-beat bursts: a
// randomly stalling AXI memory responder, a stream sink with several tready
// patterns and a frame-level reference model of addresses and pixels.
module tb_axi_frame_reader;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int BL = 4;
    localparam int FD = 8;
    localparam int N  = W * H;
    localparam int NB = N / BL;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic        frame_start;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_error;

    axi_frame_reader #(
        .C_M_AXI_TARGET_SLAVE_BASE_ADDR(BASE),
        .FRAME_WIDTH(W),
        .FRAME_HEIGHT(H),
        .BURST_LEN(BL),
        .FIFO_DEPTH(FD)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_aresetn(rst_n),
        .m_axi_araddr(araddr),
        .m_axi_arlen(arlen),
        .m_axi_arsize(arsize),
        .m_axi_arburst(arburst),
        .m_axi_arcache(arcache),
        .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata),
        .m_axi_rresp(rresp),
        .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tuser(tuser),
        .m_axis_tlast(tlast),
        .frame_start(frame_start),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .frame_error(frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus controls, written only by the main sequence.
    logic [31:0] mem [N];
    int          tmode;
    bit          stall_en;
    int          err_idx;

    // Observation logs, written only by the monitor.
    logic [39:0] ar_q  [$];
    logic [25:0] pix_q [$];
    int          done_cnt;
    int          done_bad;

    int n_cmp;
    int n_err;
    int ar_base;
    int pix_base;
    int done_base;
    int bad_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // AXI memory responder: one burst at a time, optional random stalls.
    initial begin : axi_slave
        logic        hs_ar;
        logic        hs_r;
        logic        active;
        logic [31:0] ar_a;
        int          base_n;
        int          beat;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        active  = 1'b0;
        base_n  = 0;
        beat    = 0;
        forever begin
            @(negedge clk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            ar_a  = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                active  = 1'b0;
                arready = 1'b0;
                rvalid  = 1'b0;
                rlast   = 1'b0;
                continue;
            end
            if (hs_ar) begin
                active = 1'b1;
                beat   = 0;
                base_n = int'((ar_a - BASE) >> 2);
            end
            if (hs_r) begin
                if (rlast) active = 1'b0;
                beat++;
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
            arready = !active && (stall_en ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (active && !rvalid && (!stall_en || $urandom_range(0, 2) != 0)) begin
                rvalid = 1'b1;
                rdata  = mem[(base_n + beat) % N];
                rresp  = ((base_n + beat) == err_idx) ? 2'b10 : 2'b00;
                rlast  = (beat == BL - 1);
            end
        end
    end

    // Stream sink: always ready, 1-on/3-off, or random.
    initial begin : sink
        int phase;
        phase  = 0;
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (tmode)
                0:       tready = 1'b1;
                1:       tready = (phase % 4 == 0);
                default: tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: log AR and stream handshakes, and done/busy alignment.
    initial begin : monitor
        logic prev_busy;
        prev_busy = 1'b0;
        done_cnt  = 0;
        done_bad  = 0;
        forever begin
            @(negedge clk);
            if (arvalid && arready) ar_q.push_back({arlen, araddr});
            if (tvalid && tready)   pix_q.push_back({tuser, tlast, tdata});
            if (frame_done) begin
                done_cnt++;
                if (frame_busy || !prev_busy) done_bad++;
            end
            prev_busy = frame_busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic mark();
        ar_base   = ar_q.size();
        pix_base  = pix_q.size();
        done_base = done_cnt;
        bad_base  = done_bad;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arvalid"}, 32'(arvalid), 0);
        check({tag, "_araddr"},  araddr, 0);
        check({tag, "_rready"},  32'(rready), 0);
        check({tag, "_tvalid"},  32'(tvalid), 0);
        check({tag, "_tdata"},   32'(tdata), 0);
        check({tag, "_tuser"},   32'(tuser), 0);
        check({tag, "_tlast"},   32'(tlast), 0);
        check({tag, "_busy"},    32'(frame_busy), 0);
        check({tag, "_done"},    32'(frame_done), 0);
        check({tag, "_error"},   32'(frame_error), 0);
    endtask

    // Raise frame_start, check acceptance and AR latency, then drop it.
    task automatic start_frame(input string tag);
        int lat;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy_set"}, 32'(frame_busy), 1);
        check({tag, "_err_clr"}, 32'(frame_error), 0);
        lat = 1;
        while (!arvalid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ar_latency_le3"}, 32'(lat <= 3), 1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 1);
        repeat (3) @(negedge clk);
    endtask

    // Reference: NB bursts at consecutive BL*4-byte steps, N pixels in
    // memory order, tuser on pixel 0, tlast at each line end.
    task automatic check_frame(input string tag);
        logic [39:0] a;
        logic [25:0] p;
        check({tag, "_n_ar"}, 32'(ar_q.size() - ar_base), NB);
        for (int k = 0; k < NB && (ar_base + k) < ar_q.size(); k++) begin
            a = ar_q[ar_base + k];
            check($sformatf("%s_araddr%0d", tag, k), a[31:0], BASE + 32'(k * BL * 4));
            check($sformatf("%s_arlen%0d", tag, k), 32'(a[39:32]), BL - 1);
        end
        check({tag, "_n_pix"}, 32'(pix_q.size() - pix_base), N);
        for (int n = 0; n < N && (pix_base + n) < pix_q.size(); n++) begin
            p = pix_q[pix_base + n];
            check($sformatf("%s_pix%0d", tag, n), 32'(p[23:0]), 32'(mem[n][23:0]));
            check($sformatf("%s_tuser%0d", tag, n), 32'(p[25]), 32'(n == 0));
            check($sformatf("%s_tlast%0d", tag, n), 32'(p[24]), 32'(n % W == W - 1));
        end
        check({tag, "_done_count"}, 32'(done_cnt - done_base), 1);
        check({tag, "_done_busy_align"}, 32'(done_bad - bad_base), 0);
    endtask

    initial begin : main
        bit reached;
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        tmode       = 0;
        stall_en    = 1'b0;
        err_idx     = -1;
        for (int n = 0; n < N; n++) mem[n] = 32'h00AA_0000 | 32'(n);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_arlen",   32'(arlen), BL - 1);
        check("reset_arsize",  32'(arsize), 2);
        check("reset_arburst", 32'(arburst), 1);
        check("reset_arcache", 32'(arcache), 2);
        check("reset_arprot",  32'(arprot), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, no stalls, tready always high.
        mark();
        start_frame("basic");
        wait_done("basic", 500);
        check_frame("basic");
        check("basic_error", 32'(frame_error), 0);

        // Random memory, 1-on/3-off tready, random AXI stalls.
        for (int n = 0; n < N; n++) mem[n] = $urandom();
        tmode    = 1;
        stall_en = 1'b1;
        mark();
        start_frame("bp");
        wait_done("bp", 2000);
        check_frame("bp");

        // Error response on pixel 5 (burst 1): data still delivered, flag sticky.
        for (int n = 0; n < N; n++) mem[n] = $urandom();
        tmode   = 2;
        err_idx = 5;
        mark();
        start_frame("rerr");
        wait_done("rerr", 2000);
        check_frame("rerr");
        check("rerr_error_sticky", 32'(frame_error), 1);
        err_idx = -1;

        // Next start clears the error; a second edge mid-frame is ignored.
        tmode = 1;
        mark();
        start_frame("dup");
        repeat (10) @(negedge clk);
        frame_start = 1'b1;
        repeat (2) @(negedge clk);
        frame_start = 1'b0;
        wait_done("dup", 2000);
        check_frame("dup");
        repeat (20) @(negedge clk);
        check("dup_no_extra_ar", 32'(ar_q.size() - ar_base), NB);
        check("dup_idle", 32'(frame_busy), 0);

        // Reset after 5 pixels, then a clean frame from BASE.
        mark();
        start_frame("mid");
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pix_q.size() - pix_base >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        check("mid_five_pixels", 32'(reached), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tmode = 0;
        mark();
        start_frame("fresh");
        wait_done("fresh", 2000);
        check_frame("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
